pnr_multi_delay_trigger: RTL and testbench

Parametrised successor to the single-output PNR delayed trigger. A Schmitt-trigger edge detector on one ADC channel starts a timing sequence that drives NOUT independently delayed pulse outputs, each with its own delay and pulse width. The block adds single-shot/re-arm mode, per-sequence latching of the timing configuration, saturating threshold arithmetic, and accepted/missed trigger counters. It sits between the ADC data path and the PNR gating/acquisition logic in the ADC_CLK domain.

---
 rtl/pnr_multi_delay_trigger_if.sv | 36 +++
 rtl/pnr_multi_delay_trigger.sv | 163 ++++++++++++++++
 tb/tb_pnr_multi_delay_trigger.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pnr_multi_delay_trigger_if.sv
// Sample/threshold configuration in, trigger, delayed pulses and counters out.
// The trigger block is the slave; the ADC path and control registers drive the master side.
interface pnr_multi_delay_trigger_if #(
    parameter int DW   = 14,
    parameter int CW   = 32,
    parameter int WW   = 16,
    parameter int NOUT = 4
);
    logic signed [DW-1:0]   trig_source_sig;
    logic signed [DW-1:0]   trig_threshold;
    logic [DW-1:0]          trig_hysteresis;
    logic                   trig_is_posedge;
    logic                   trig_enable;
    logic                   trig_single;
    logic                   trig_rearm;
    logic [CW-1:0]          trig_clearance;
    logic [NOUT*CW-1:0]     pnr_delay;
    logic [NOUT*WW-1:0]     pnr_width;
    logic                   trigger;
    logic [NOUT-1:0]        delayed_trigger;
    logic                   busy;
    logic [CW-1:0]          trig_count;
    logic [15:0]            miss_count;

    modport master (
        output trig_source_sig, trig_threshold, trig_hysteresis, trig_is_posedge,
               trig_enable, trig_single, trig_rearm, trig_clearance, pnr_delay, pnr_width,
        input  trigger, delayed_trigger, busy, trig_count, miss_count
    );

    modport slave (
        input  trig_source_sig, trig_threshold, trig_hysteresis, trig_is_posedge,
               trig_enable, trig_single, trig_rearm, trig_clearance, pnr_delay, pnr_width,
        output trigger, delayed_trigger, busy, trig_count, miss_count
    );
endinterface

// File: rtl/pnr_multi_delay_trigger.sv
// Schmitt-trigger edge detector on one ADC channel launching NOUT independently delayed pulses.
// Latency: trigger 2 edges after a qualifying sample; output k rises d_k+2 cycles after the accepted trigger.
// No backpressure: triggers arriving outside IDLE are dropped and counted in miss_count.
module pnr_multi_delay_trigger #(
    parameter int DW   = 14,
    parameter int CW   = 32,
    parameter int WW   = 16,
    parameter int NOUT = 4
) (
    input  logic                      ADC_CLK,
    input  logic                      rstn_i,
    pnr_multi_delay_trigger_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic signed [DW+1:0] SAT_MAX = $signed({3'b000, {(DW-1){1'b1}}});
    localparam logic signed [DW+1:0] SAT_MIN = $signed({3'b111, {(DW-1){1'b0}}});

    logic signed [DW-1:0] w_smp;
    logic signed [DW-1:0] w_thr;
    logic signed [DW+1:0] w_sum_p;
    logic signed [DW+1:0] w_sum_m;
    logic signed [DW-1:0] w_treshp;
    logic signed [DW-1:0] w_treshm;
    logic signed [DW-1:0] r_treshp;
    logic signed [DW-1:0] r_treshm;
    logic                 r_det_p;
    logic                 r_det_n;
    logic                 r_sel_q;
    logic                 r_trigger;
    logic                 w_sel;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_busy;
    logic                 w_accept;
    logic                 w_miss;
    logic                 w_exit;
    logic [CW-1:0]        r_cnt;
    logic [CW:0]          w_cnt_x;
    logic [CW-1:0]        r_l_clear;
    logic [NOUT*CW-1:0]   r_l_delay;
    logic [NOUT*WW-1:0]   r_l_width;
    logic [NOUT-1:0]      w_hit;
    logic [NOUT-1:0]      w_out_ok;
    logic [NOUT-1:0]      r_dly;
    logic [CW-1:0]        r_trig_cnt;
    logic [15:0]          r_miss_cnt;

    // Two guard bits keep thr+hyst exact for any unsigned hysteresis before clamping.
    assign w_smp    = $signed(bus.trig_source_sig);
    assign w_thr    = $signed(bus.trig_threshold);
    assign w_sum_p  = {{2{w_thr[DW-1]}}, w_thr} + {2'b00, bus.trig_hysteresis};
    assign w_sum_m  = {{2{w_thr[DW-1]}}, w_thr} - {2'b00, bus.trig_hysteresis};
    assign w_treshp = (w_sum_p > SAT_MAX) ? SAT_MAX[DW-1:0] : w_sum_p[DW-1:0];
    assign w_treshm = (w_sum_m < SAT_MIN) ? SAT_MIN[DW-1:0] : w_sum_m[DW-1:0];
    assign w_sel    = bus.trig_is_posedge ? r_det_p : r_det_n;

    always_ff @(posedge ADC_CLK or negedge rstn_i) begin
        if (!rstn_i) begin
            r_treshp  <= '0;
            r_treshm  <= '0;
            r_det_p   <= 1'b0;
            r_det_n   <= 1'b0;
            r_sel_q   <= 1'b0;
            r_trigger <= 1'b0;
        end else begin
            r_treshp <= w_treshp;
            r_treshm <= w_treshm;
            if (w_smp >= w_thr)
                r_det_p <= 1'b1;
            else if (w_smp < r_treshm)
                r_det_p <= 1'b0;
            if (w_smp <= w_thr)
                r_det_n <= 1'b1;
            else if (w_smp > r_treshp)
                r_det_n <= 1'b0;
            r_sel_q   <= w_sel;
            r_trigger <= w_sel & ~r_sel_q;
        end
    end

    assign w_cnt_x = {1'b0, r_cnt};

    // Window ends are one bit wider than the counter so delay+width never wraps.
    for (genvar k = 0; k < NOUT; k++) begin : g_out
        logic [CW:0] w_beg;
        logic [CW:0] w_end;
        assign w_beg       = {1'b0, r_l_delay[k*CW +: CW]};
        assign w_end       = w_beg + {{(CW+1-WW){1'b0}}, r_l_width[k*WW +: WW]};
        assign w_hit[k]    = w_busy && (w_cnt_x >= w_beg) && (w_cnt_x < w_end);
        assign w_out_ok[k] = (r_l_width[k*WW +: WW] == '0) || (w_cnt_x >= w_end);
    end

    assign w_exit = w_busy && (r_cnt >= r_l_clear) && (&w_out_ok);

    always_ff @(posedge ADC_CLK or negedge rstn_i) begin
        if (!rstn_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)       w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_exit)         w_state_nxt = bus.trig_single ? ST_DONE : ST_IDLE;
            ST_DONE: if (bus.trig_rearm) w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = 1'b0;
        w_accept = 1'b0;
        w_miss   = 1'b0;
        case (r_state)
            ST_IDLE: w_accept = r_trigger & bus.trig_enable;
            ST_BUSY: begin
                w_busy = 1'b1;
                w_miss = r_trigger;
            end
            ST_DONE: w_miss = r_trigger;
            default: ;
        endcase
    end

    always_ff @(posedge ADC_CLK or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt      <= '0;
            r_l_clear  <= '0;
            r_l_delay  <= '0;
            r_l_width  <= '0;
            r_dly      <= '0;
            r_trig_cnt <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_cnt      <= '0;
                r_l_clear  <= bus.trig_clearance;
                r_l_delay  <= bus.pnr_delay;
                r_l_width  <= bus.pnr_width;
                r_trig_cnt <= r_trig_cnt + CW'(1);
            end else if (w_busy && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_miss && (r_miss_cnt != 16'hFFFF))
                r_miss_cnt <= r_miss_cnt + 16'd1;
            r_dly <= w_hit;
        end
    end

    assign bus.trigger         = r_trigger;
    assign bus.delayed_trigger = r_dly;
    assign bus.busy            = w_busy;
    assign bus.trig_count      = r_trig_cnt;
    assign bus.miss_count      = r_miss_cnt;
endmodule

// File: tb/tb_pnr_multi_delay_trigger.sv
// Directed scenarios against a time-based reference of the trigger sequencer,
// plus literal checks on pulse placement, counters and reset behaviour.
module tb_pnr_multi_delay_trigger;
    localparam int DW   = 14;
    localparam int CW   = 32;
    localparam int WW   = 16;
    localparam int NOUT = 4;
    localparam int SMAX = (1 << (DW-1)) - 1;
    localparam int SMIN = -(1 << (DW-1));

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    pnr_multi_delay_trigger_if #(.DW(DW), .CW(CW), .WW(WW), .NOUT(NOUT)) bus ();

    pnr_multi_delay_trigger #(.DW(DW), .CW(CW), .WW(WW), .NOUT(NOUT)) dut (
        .ADC_CLK (clk),
        .rstn_i  (rstn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: the sequence is described by its acceptance cycle T and length M.
    int              m_cyc;
    bit              m_dp, m_dn, m_sel_last, m_trig;
    int              m_tp, m_tm;
    bit              m_active, m_done;
    int              m_T, m_M;
    int              m_d [NOUT];
    int              m_w [NOUT];
    int              m_tc, m_mc;
    bit              e_busy;
    logic [NOUT-1:0] e_dly;

    always @(posedge clk or negedge rstn) begin
        bit busy_prev, idle_prev, done_prev, sel_now;
        int e, smp, thr, hyst;
        if (!rstn) begin
            m_cyc = 0; m_dp = 0; m_dn = 0; m_sel_last = 0; m_trig = 0;
            m_tp = 0; m_tm = 0; m_active = 0; m_done = 0; m_T = 0; m_M = 0;
            m_tc = 0; m_mc = 0; e_busy = 0; e_dly = '0;
        end else begin
            m_cyc++;
            e = m_cyc;
            busy_prev = m_active && (e - 1 >= m_T + 1) && (e - 1 <= m_T + 1 + m_M);
            done_prev = m_done;
            idle_prev = !busy_prev && !done_prev;
            if (m_active && e == m_T + 2 + m_M) begin
                m_active = 0;
                m_done   = bus.trig_single;
            end
            if (done_prev && bus.trig_rearm) m_done = 0;
            if (m_trig) begin
                if (idle_prev && bus.trig_enable) begin
                    m_T = e - 1;
                    m_M = int'(bus.trig_clearance);
                    for (int k = 0; k < NOUT; k++) begin
                        m_d[k] = int'(bus.pnr_delay[k*CW +: CW]);
                        m_w[k] = int'(bus.pnr_width[k*WW +: WW]);
                        if (m_w[k] > 0 && m_d[k] + m_w[k] > m_M) m_M = m_d[k] + m_w[k];
                    end
                    m_active = 1;
                    m_tc++;
                end else if (!idle_prev && m_mc < 65535) begin
                    m_mc++;
                end
            end
            smp  = int'($signed(bus.trig_source_sig));
            thr  = int'($signed(bus.trig_threshold));
            hyst = int'(bus.trig_hysteresis);
            sel_now    = bus.trig_is_posedge ? m_dp : m_dn;
            m_trig     = sel_now && !m_sel_last;
            m_sel_last = sel_now;
            if (smp >= thr) m_dp = 1; else if (smp < m_tm) m_dp = 0;
            if (smp <= thr) m_dn = 1; else if (smp > m_tp) m_dn = 0;
            m_tp = (thr + hyst > SMAX) ? SMAX : thr + hyst;
            m_tm = (thr - hyst < SMIN) ? SMIN : thr - hyst;
            e_busy = m_active && (e >= m_T + 1) && (e <= m_T + 1 + m_M);
            for (int k = 0; k < NOUT; k++)
                e_dly[k] = m_active && (m_w[k] > 0) && (e >= m_T + 2 + m_d[k]) && (e < m_T + 2 + m_d[k] + m_w[k]);
        end
    end

    always @(negedge clk) begin
        chk("trigger",         bus.trigger,         m_trig);
        chk("delayed_trigger", bus.delayed_trigger, e_dly);
        chk("busy",            bus.busy,            e_busy);
        chk("trig_count",      bus.trig_count,      m_tc);
        chk("miss_count",      bus.miss_count,      m_mc);
    end

    // Observer of DUT outputs for the literal, hand-computed checks.
    int t_trig, n_trig, last_busy;
    int rise [NOUT];
    int hic  [NOUT];

    always @(negedge clk) begin
        if (bus.trigger === 1'b1) begin
            n_trig++;
            if (t_trig < 0) t_trig = m_cyc;
        end
        if (bus.busy === 1'b1) last_busy = m_cyc;
        for (int k = 0; k < NOUT; k++)
            if (bus.delayed_trigger[k] === 1'b1) begin
                if (rise[k] < 0) rise[k] = m_cyc;
                hic[k]++;
            end
    end

    task automatic clear_obs();
        t_trig = -1; n_trig = 0; last_busy = -1;
        for (int k = 0; k < NOUT; k++) begin
            rise[k] = -1;
            hic[k]  = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_smp(input int v);
        bus.trig_source_sig = v[DW-1:0];
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_trigger"}, bus.trigger,         0);
        chk({tag, "_delayed"}, bus.delayed_trigger, 0);
        chk({tag, "_busy"},    bus.busy,            0);
        chk({tag, "_tcount"},  bus.trig_count,      0);
        chk({tag, "_mcount"},  bus.miss_count,      0);
    endtask

    // Delays 0/5/10/100, widths 1/3/0/2, no clearance.
    task automatic run_s1(input string tag);
        int c_set;
        c_set = -1;
        clear_obs();
        for (int v = 900; v <= 1100; v += 25) begin
            if (v >= 1000 && c_set < 0) c_set = m_cyc;
            set_smp(v);
            tick(1);
        end
        tick(120);
        chk({tag, "_latency"},   t_trig - c_set,    2);
        chk({tag, "_ntrig"},     n_trig,            1);
        chk({tag, "_o0_rise"},   rise[0] - t_trig,  2);
        chk({tag, "_o0_width"},  hic[0],            1);
        chk({tag, "_o1_rise"},   rise[1] - t_trig,  7);
        chk({tag, "_o1_width"},  hic[1],            3);
        chk({tag, "_o2_width"},  hic[2],            0);
        chk({tag, "_o3_rise"},   rise[3] - t_trig,  102);
        chk({tag, "_o3_width"},  hic[3],            2);
        chk({tag, "_busy_last"}, last_busy - t_trig, 103);
        chk({tag, "_busy_now"},  bus.busy,          0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.trig_source_sig = '0;
        bus.trig_threshold  = 14'sd1000;
        bus.trig_hysteresis = 14'd50;
        bus.trig_is_posedge = 1'b1;
        bus.trig_enable     = 1'b1;
        bus.trig_single     = 1'b0;
        bus.trig_rearm      = 1'b0;
        bus.trig_clearance  = '0;
        bus.pnr_delay       = {32'd100, 32'd10, 32'd5, 32'd0};
        bus.pnr_width       = {16'd2, 16'd0, 16'd3, 16'd1};
        clear_obs();
        tick(3);
        chk_idle_outputs("reset");
        rstn = 1'b1;
        tick(3);

        // Single clean crossing.
        run_s1("s1");
        chk("s1_tcount", bus.trig_count, 1);
        chk("s1_mcount", bus.miss_count, 0);

        // Noise around the threshold stays inside the hysteresis band.
        set_smp(900);
        tick(5);
        clear_obs();
        set_smp(1010);
        tick(1);
        for (int i = 0; i < 20; i++) begin
            set_smp((i % 2 == 0) ? 990 : 1010);
            tick(1);
        end
        tick(110);
        chk("s2_noise_ntrig", n_trig, 1);
        clear_obs();
        set_smp(940);
        tick(3);
        set_smp(1010);
        tick(120);
        chk("s2_rearm_ntrig", n_trig, 1);
        chk("s2_tcount", bus.trig_count, 3);

        // Upper threshold clamps at the top of the sample range.
        bus.trig_enable = 1'b0;
        set_smp(8191);
        tick(3);
        bus.trig_is_posedge = 1'b0;
        bus.trig_threshold  = 14'sd8000;
        bus.trig_hysteresis = 14'd1000;
        tick(3);
        bus.trig_enable = 1'b1;
        tick(2);
        clear_obs();
        set_smp(7990);
        tick(5);
        set_smp(8191);
        tick(10);
        set_smp(7990);
        tick(110);
        chk("s3_sat_ntrig", n_trig, 1);
        chk("s3_tcount", bus.trig_count, 4);
        chk("s3_mcount", bus.miss_count, 0);
        bus.trig_enable = 1'b0;
        set_smp(900);
        bus.trig_threshold  = 14'sd1000;
        bus.trig_hysteresis = 14'd50;
        tick(3);
        bus.trig_is_posedge = 1'b1;
        tick(3);
        bus.trig_enable = 1'b1;
        tick(2);

        // Clearance-extended sequence with a crossing during BUSY.
        bus.trig_clearance = 32'd200;
        clear_obs();
        set_smp(1010);
        tick(10);
        set_smp(900);
        tick(8);
        set_smp(1010);
        tick(10);
        chk("s4_mcount", bus.miss_count, 1);
        chk("s4_tcount", bus.trig_count, 5);
        chk("s4_busy",   bus.busy, 1);
        for (int i = 0; i < 400; i++) begin
            if (bus.busy !== 1'b1) break;
            tick(1);
        end
        chk("s4_busy_end", bus.busy, 0);
        chk("s4_busy_len", last_busy - t_trig, 201);
        set_smp(900);
        tick(3);
        set_smp(1010);
        tick(5);
        chk("s4_accept_after", bus.trig_count, 6);
        chk("s4_busy_again",   bus.busy, 1);
        bus.trig_clearance = '0;
        tick(210);
        set_smp(900);
        tick(3);

        // Single-shot: DONE holds until re-armed.
        bus.trig_single = 1'b1;
        set_smp(1010);
        tick(3);
        chk("s5_first", bus.trig_count, 7);
        set_smp(900);
        tick(494);
        set_smp(1010);
        tick(5);
        chk("s5_done_tcount", bus.trig_count, 7);
        chk("s5_done_mcount", bus.miss_count, 2);
        chk("s5_done_busy",   bus.busy, 0);
        set_smp(900);
        tick(3);
        bus.trig_rearm = 1'b1;
        tick(1);
        bus.trig_rearm = 1'b0;
        tick(2);
        set_smp(1010);
        tick(5);
        chk("s5_rearm_tcount", bus.trig_count, 8);
        chk("s5_rearm_busy",   bus.busy, 1);
        tick(110);
        set_smp(900);
        bus.trig_single = 1'b0;
        bus.trig_rearm  = 1'b1;
        tick(1);
        bus.trig_rearm = 1'b0;
        tick(3);

        // Reset in the middle of a pulse.
        clear_obs();
        set_smp(1010);
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (bus.delayed_trigger[3] === 1'b1) break;
        end
        chk("s6_pulse_seen", bus.delayed_trigger[3], 1);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk_idle_outputs("s6_async");
        set_smp(900);
        tick(3);
        rstn = 1'b1;
        tick(3);
        run_s1("s6");
        chk("s6_tcount", bus.trig_count, 1);
        chk("s6_mcount", bus.miss_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
